// File: rtl/up_controller_pkg.sv
// up_controller_pkg: shared state enum, etapos width helper and UP pipeline depth default
package up_controller_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} up_state_t;
  localparam int MAXLOGFI = 3;
  localparam int PIPELINEMULT = 2;
  localparam int UP_LAT_DEFAULT = MAXLOGFI + PIPELINEMULT + 1;
  function automatic int etapos_w(input int width, input int int_bits);
    return $clog2(width - int_bits - 1 + 2);
  endfunction
endpackage

// File: rtl/up_lat_tracker.sv
// up_lat_tracker: {valid, addr} delay line matching the UP datapath latency
module up_lat_tracker #(
  parameter int DEPTH = 1,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          empty
);
  logic [DEPTH-1:0] v;
  logic [AW-1:0] a [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) a[i] <= '0;
    end else begin
      v[0] <= in_valid;
      a[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        a[i] <= a[i-1];
      end
    end
  end
  // empty once only the output stage (being written this cycle) may still hold an entry
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) if (v[i]) empty = 1'b0;
  end
  assign out_valid = v[DEPTH-1];
  assign out_addr = a[DEPTH-1];
endmodule

// File: rtl/up_controller.sv
// up_controller: UP weight/bias update sequencer; UP_PIPELINE_EN selects a pipelined datapath
module up_controller
  import up_controller_pkg::*;
#(
  parameter int cpc = 32,
  parameter int width = 10,
  parameter int int_bits = 2,
  parameter int UP_LAT = UP_LAT_DEFAULT,
  localparam int EW = etapos_w(width, int_bits),
  localparam int AW = cpc > 1 ? $clog2(cpc) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [EW-1:0] etapos_in,
  input  logic          del_valid,
  output logic [EW-1:0] etapos,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          busy,
  output logic          done
);
`ifdef UP_PIPELINE_EN
  localparam int L = 1 + UP_LAT;
`else
  localparam int L = 1 + 0 * UP_LAT;
`endif
  up_state_t st, nxt;
  logic [AW-1:0] cnt;
  logic last, empty;
  always_comb begin
    nxt = st;
    rd_en = st == ISSUE && del_valid;
    last = rd_en && cnt == AW'(cpc - 1);
    unique case (st)
      IDLE:  nxt = start ? (etapos_in == '0 ? DRAIN : ISSUE) : IDLE;
      ISSUE: nxt = last ? DRAIN : ISSUE;
      DRAIN: nxt = empty ? DONE : DRAIN;
      DONE:  nxt = IDLE;
    endcase
  end
  // a zero exponent passes through an empty DRAIN so busy covers exactly one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      etapos <= '0;
    end else begin
      st <= nxt;
      if (st == IDLE && start) begin
        etapos <= etapos_in;
        cnt <= '0;
      end else if (rd_en) cnt <= last ? '0 : cnt + 1'b1;
    end
  end
  up_lat_tracker #(.DEPTH(L), .AW(AW)) u_trk (
    .clk(clk), .rst(reset), .in_valid(rd_en), .in_addr(cnt),
    .out_valid(wr_en), .out_addr(wr_addr), .empty(empty)
  );
  assign rd_addr = cnt;
  assign busy = st == ISSUE || st == DRAIN;
  assign done = st == DONE;
endmodule

// File: tb/tb_up_controller.sv
// tb_up_controller: randomized scenario bench against a schedule-level reference model
module tb_up_controller;
  localparam int CPC = 5;
  localparam int EW = 4;
  localparam int AW = 3;
  localparam int MAXC = 80;
`ifdef UP_PIPELINE_EN
  localparam int L = 7;
`else
  localparam int L = 1;
`endif
  typedef logic [2*AW+EW+3:0] obs_t;
  logic clk = 0, reset = 1, start = 0, del_valid = 0;
  logic [EW-1:0] etapos_in = '0, etapos;
  logic rd_en, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  obs_t exp_q [MAXC];
  logic dv [MAXC];
  logic st [MAXC];
  logic [EW-1:0] ein [MAXC];
  logic [EW-1:0] prev_eta = '0;
  int checks = 0, passed = 0;

  up_controller #(.cpc(CPC)) dut (
    .clk(clk), .reset(reset), .start(start), .etapos_in(etapos_in), .del_valid(del_valid),
    .etapos(etapos), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // reads happen on the first CPC valid cycles after start; each write trails its read by L
  function automatic int model(input logic [EW-1:0] eta, input int rst_at);
    logic e_rd [MAXC], e_wr [MAXC];
    logic [AW-1:0] e_ra [MAXC], e_wa [MAXC];
    int issued = 0, last = 0, fin;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_wr[c] = 0; e_ra[c] = '0; e_wa[c] = '0;
    end
    if (eta != 0)
      for (int c = 1; c < MAXC - L && issued < CPC; c++)
        if (dv[c]) begin
          e_rd[c] = 1; e_ra[c] = AW'(issued);
          e_wr[c+L] = 1; e_wa[c+L] = AW'(issued);
          issued++; last = c;
        end
    fin = eta == 0 ? 2 : last + L + 1;
    for (int c = 0; c < MAXC; c++) begin
      exp_q[c] = {e_rd[c], e_ra[c], e_wr[c], e_wa[c], c >= 1 && c < fin, c == fin,
                  c == 0 ? prev_eta : eta};
      if (rst_at >= 0 && c > rst_at) exp_q[c] = '0;
    end
    for (int c = 0; c < MAXC; c++)
      if (c > (rst_at >= 0 ? rst_at : fin)) st[c] = 0;
    prev_eta = rst_at >= 0 ? '0 : eta;
    return rst_at >= 0 ? rst_at + 3 : fin;
  endfunction

  function automatic void stim(input logic [EW-1:0] eta, input int stall_pct);
    for (int c = 0; c < MAXC; c++) begin
      dv[c] = c > 40 ? 1'b1 : ($urandom_range(99) >= stall_pct);
      st[c] = c == 0 ? 1'b1 : ($urandom_range(3) == 0);
      ein[c] = c == 0 ? eta : EW'($urandom);
    end
  endfunction

  task automatic cycle(input int c, input int rst_at, output obs_t got);
    start = st[c]; etapos_in = ein[c]; del_valid = dv[c]; reset = c == rst_at;
    @(negedge clk);
    got = {rd_en, rd_en ? rd_addr : {AW{1'b0}}, wr_en, wr_en ? wr_addr : {AW{1'b0}},
           busy, done, etapos};
    @(posedge clk); #1;
    reset = 0; start = 0;
  endtask

  task automatic test_reset;
    obs_t got;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    got = {rd_en, rd_addr, wr_en, wr_addr, busy, done, etapos};
    checks++;
    if (got !== '0) $display("FAIL reset: got %h expected 0", got); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    obs_t got;
    int fin;
    stim(2, 0);
    fin = model(2, -1);
    for (int c = 0; c <= fin; c++) begin
      cycle(c, -1, got);
      checks++;
      if (got !== exp_q[c]) $display("FAIL basic c%0d: got %h expected %h", c, got, exp_q[c]);
      else passed++;
    end
  endtask

  task automatic test_stall;
    obs_t got;
    int fin;
    stim(5, 0);
    dv[2] = 0; dv[3] = 0;
    fin = model(5, -1);
    checks++;
    if (fin !== CPC + L + 3) $display("FAIL stall_end: got %0d expected %0d", fin, CPC + L + 3);
    else passed++;
    for (int c = 0; c <= fin; c++) begin
      cycle(c, -1, got);
      checks++;
      if (got !== exp_q[c]) $display("FAIL stall c%0d: got %h expected %h", c, got, exp_q[c]);
      else passed++;
    end
  endtask

  task automatic test_zero_eta;
    obs_t got;
    int fin;
    stim(0, 0);
    st[1] = 1; ein[1] = 3;
    fin = model(0, -1);
    for (int c = 0; c <= fin + 2; c++) begin
      if (c > fin) begin st[c] = 0; dv[c] = 1; exp_q[c] = '0; end
      cycle(c, -1, got);
      checks++;
      if (got !== exp_q[c]) $display("FAIL zero_eta c%0d: got %h expected %h", c, got, exp_q[c]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    obs_t got;
    int fin;
    stim(6, 0);
    fin = model(6, 5);
    for (int c = 0; c <= fin; c++) begin
      cycle(c, 5, got);
      checks++;
      if (got !== exp_q[c]) $display("FAIL reset_mid c%0d: got %h expected %h", c, got, exp_q[c]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    obs_t got;
    int fin;
    logic [EW-1:0] eta;
    for (int p = 0; p < 6; p++) begin
      eta = p == 3 ? '0 : EW'($urandom_range(2**EW - 1, 1));
      stim(eta, 30);
      fin = model(eta, -1);
      for (int c = 0; c <= fin; c++) begin
        cycle(c, -1, got);
        checks++;
        if (got !== exp_q[c]) $display("FAIL b2b p%0d c%0d: got %h expected %h", p, c, got, exp_q[c]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_zero_eta;
    test_reset_mid;
    test_basic;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
